// File: rtl/simd_acc_pkg.sv
// Shared types for the SIMD accumulator bank: op encoding, FSM state codes and helpers.
package simd_acc_pkg;

   typedef enum logic [1:0] {
      OP_WRITE   = 2'd0,
      OP_ADD     = 2'd1,
      OP_SUB     = 2'd2,
      OP_ADD_SAT = 2'd3
   } acc_op_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   // Every op except WRITE needs the old word and therefore the storage read port.
   function automatic logic is_rmw(input acc_op_e op);
      return op != OP_WRITE;
   endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// Combinational per-lane datapath: WRITE/ADD/SUB/ADD_SAT on packed lanes, no carry between lanes.
module simd_lane_alu
   import simd_acc_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int LANE_WIDTH = 16
) (
   input  acc_op_e               op_i,
   input  logic [DATA_WIDTH-1:0] old_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  ovf_o
);

   localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

   logic [LANE_WIDTH-1:0] a, b, r;
   logic [LANE_WIDTH:0]   s;

   // NOTE: every variable gets a default at the top so no path can infer a latch.
   always_comb begin
      result_o = '0;
      ovf_o    = 1'b0;
      a        = '0;
      b        = '0;
      r        = '0;
      s        = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         a = old_i[l*LANE_WIDTH +: LANE_WIDTH];
         b = data_i[l*LANE_WIDTH +: LANE_WIDTH];
         s = {1'b0, a} + {1'b0, b};
         case (op_i)
            OP_WRITE: r = b;
            OP_ADD:   r = s[LANE_WIDTH-1:0];
            OP_SUB:   r = a - b;
            default: begin
               r     = s[LANE_WIDTH] ? '1 : s[LANE_WIDTH-1:0];
               ovf_o = ovf_o | s[LANE_WIDTH];
            end
         endcase
         result_o[l*LANE_WIDTH +: LANE_WIDTH] = r;
      end
   end

endmodule

// File: rtl/simd_acc_bank.sv
// SIMD read-modify-write accumulator bank with full-depth forwarding, a shared read port
// and a hardware clear sweep.
module simd_acc_bank
   import simd_acc_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 64,
   parameter int LANE_WIDTH = 16,
   parameter int RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [1:0]            wr_op,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  clr_start,
   output logic                  busy,
   output logic                  clr_done,
   output logic                  ovf
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int HIST  = RD_LAT + 1;

   typedef struct packed {
      logic                  valid;
      acc_op_e               op;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } pipe_ctrl_t;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } hist_t;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  run_q, clr_done_q, ovf_q;
   pipe_ctrl_t            ctrl_q [RD_LAT];
   logic [RD_LAT-1:0]     ext_q;
   hist_t                 hist_q [HIST];
   logic [DATA_WIDTH-1:0] hold_q;
   logic [DATA_WIDTH-1:0] mem    [DEPTH];
   logic [DATA_WIDTH-1:0] rdat_q [RD_LAT];

   acc_op_e               op_in;
   logic                  idle, wr_acc, rmw_acc, rd_acc, pipe_busy, cmp_valid, alu_ovf;
   logic                  clearing, we;
   logic [ADDR_WIDTH-1:0] raddr, waddr;
   logic [DATA_WIDTH-1:0] wdata, old_data, alu_res;
   pipe_ctrl_t            cmp;

   assign op_in    = acc_op_e'(wr_op);
   assign idle     = run_q && (state_q == ST_IDLE);
   assign wr_ready = idle;
   assign wr_acc   = wr_valid && wr_ready;
   assign rmw_acc  = wr_acc && is_rmw(op_in);
   assign rd_ready = idle && !rmw_acc;
   assign rd_acc   = rd_en && rd_ready;
   assign raddr    = rmw_acc ? wr_addr : rd_addr;

   assign busy     = (state_q != ST_IDLE);
   assign clr_done = clr_done_q;
   assign ovf      = ovf_q;
   assign rd_valid = ext_q[RD_LAT-1];
   assign rd_data  = rd_valid ? rdat_q[RD_LAT-1] : hold_q;

   assign cmp       = ctrl_q[RD_LAT-1];
   assign cmp_valid = cmp.valid;
   assign clearing  = (state_q == ST_CLEAR);
   assign we        = clearing || hist_q[0].valid;
   assign waddr     = clearing ? cnt_q : hist_q[0].addr;
   assign wdata     = clearing ? '0 : hist_q[0].data;

   always_comb begin
      pipe_busy = hist_q[0].valid | (|ext_q);
      for (int k = 0; k < RD_LAT; k++) pipe_busy = pipe_busy | ctrl_q[k].valid;
   end

   // Oldest history entry first, so the youngest matching result wins.
   always_comb begin
      old_data = rdat_q[RD_LAT-1];
      for (int i = HIST-1; i >= 0; i--) begin
         if (hist_q[i].valid && hist_q[i].addr == cmp.addr) old_data = hist_q[i].data;
      end
   end

   simd_lane_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_WIDTH (LANE_WIDTH)
   ) u_alu (
      .op_i     (cmp.op),
      .old_i    (old_data),
      .data_i   (cmp.data),
      .result_o (alu_res),
      .ovf_o    (alu_ovf)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE:  if (clr_start && run_q) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (!pipe_busy) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         run_q      <= 1'b0;
         clr_done_q <= 1'b0;
         ovf_q      <= 1'b0;
         ext_q      <= '0;
         hold_q     <= '0;
         for (int k = 0; k < RD_LAT; k++) ctrl_q[k] <= '0;
         for (int i = 0; i < HIST; i++) hist_q[i] <= '0;
      end else begin
         run_q      <= 1'b1;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_done_q <= clearing && (cnt_q == '1);
         ovf_q      <= cmp_valid && alu_ovf;
         ext_q      <= (ext_q << 1) | RD_LAT'(rd_acc);
         if (rd_valid) hold_q <= rd_data;
         ctrl_q[0]  <= '{valid: wr_acc, op: op_in, addr: wr_addr, data: wr_data};
         for (int k = 1; k < RD_LAT; k++) ctrl_q[k] <= ctrl_q[k-1];
         hist_q[0]  <= '{valid: cmp_valid, addr: cmp.addr, data: alu_res};
         for (int i = 1; i < HIST; i++) hist_q[i] <= hist_q[i-1];
      end
   end

   // NOTE: the storage array and its read-data pipeline are deliberately left without reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rmw_acc || rd_acc) rdat_q[0] <= mem[raddr];
      for (int k = 1; k < RD_LAT; k++) rdat_q[k] <= rdat_q[k-1];
   end

endmodule

// File: tb/tb_simd_acc_bank.sv
// Directed scoreboard bench for simd_acc_bank: reads and ovf pulses are checked by monitors.
module tb_simd_acc_bank;
   import simd_acc_pkg::*;

   localparam int AW        = 9;
   localparam int DW        = 64;
   localparam int LW        = 16;
   localparam int TB_RD_LAT = 2;
   localparam int DEPTH     = 2**AW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          wr_valid, wr_ready, rd_en, rd_ready, rd_valid;
   logic          clr_start, busy, clr_done, ovf;
   logic [1:0]    wr_op;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data, rd_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rd_exp_t;

   rd_exp_t rd_q[$];
   int      ovf_q[$];
   rd_exp_t mon_e;
   int      mon_c;

   simd_acc_bank #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LANE_WIDTH (LW),
      .RD_LAT     (TB_RD_LAT)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_op     (wr_op),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_ready  (rd_ready),
      .rd_addr   (rd_addr),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .clr_start (clr_start),
      .busy      (busy),
      .clr_done  (clr_done),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every rd_valid / ovf pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (rd_valid === 1'b1) begin
            if (rd_q.size() == 0) check("rd_valid_unexpected", 64'd1, 64'd0);
            else begin
               mon_e = rd_q.pop_front();
               check("rd_latency", 64'(cyc), 64'(mon_e.due));
               check("rd_data", rd_data, mon_e.data);
            end
         end
         if (ovf === 1'b1) begin
            if (ovf_q.size() == 0) check("ovf_unexpected", 64'd1, 64'd0);
            else begin
               mon_c = ovf_q.pop_front();
               check("ovf_cycle", 64'(cyc), 64'(mon_c));
            end
         end
      end
   end

   task automatic step(input logic wv, input acc_op_e op, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic exp_ovf, input logic re,
                       input logic [AW-1:0] ra, input logic [DW-1:0] rexp, input logic exp_rr);
      wr_valid = wv;
      wr_op    = op;
      wr_addr  = wa;
      wr_data  = wd;
      rd_en    = re;
      rd_addr  = ra;
      @(negedge clk);
      if (wv) check("wr_ready", 64'(wr_ready), 64'd1);
      if (re) check("rd_ready", 64'(rd_ready), 64'(exp_rr));
      if (wv && wr_ready && exp_ovf) ovf_q.push_back(cyc + TB_RD_LAT + 1);
      if (re && rd_ready) rd_q.push_back('{due: cyc + TB_RD_LAT, data: rexp});
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      rd_en    = 1'b0;
   endtask

   task automatic op(input acc_op_e o, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic exp_ovf);
      step(1'b1, o, a, d, exp_ovf, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      step(1'b0, OP_WRITE, '0, '0, 1'b0, 1'b1, a, exp, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((rd_q.size() != 0 || ovf_q.size() != 0) && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_rd_queue", 64'(rd_q.size()), 64'd0);
      check("drain_ovf_queue", 64'(ovf_q.size()), 64'd0);
   endtask

   initial begin
      int n;
      rstn      = 1'b0;
      wr_valid  = 1'b0;
      wr_op     = 2'd0;
      wr_addr   = '0;
      wr_data   = '0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      clr_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_rd_ready", 64'(rd_ready), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_clr_done", 64'(clr_done), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      rstn = 1'b1;
      idle(1);
      check("post_rst_wr_ready", 64'(wr_ready), 64'd1);

      // Plain write, then a read alongside another WRITE, and a read blocked by an RMW.
      op(OP_WRITE, 9'd5, 64'h0001_0002_0003_0004, 1'b0);
      idle(TB_RD_LAT + 3);
      step(1'b1, OP_WRITE, 9'd6, 64'h0000_0000_0000_00FF, 1'b0,
           1'b1, 9'd5, 64'h0001_0002_0003_0004, 1'b1);
      step(1'b1, OP_ADD, 9'd6, 64'h0000_0000_0000_0001, 1'b0,
           1'b1, 9'd5, 64'h0001_0002_0003_0004, 1'b0);
      drain();
      @(negedge clk);
      check("rd_data_hold_valid", 64'(rd_valid), 64'd0);
      check("rd_data_hold", rd_data, 64'h0001_0002_0003_0004);
      @(posedge clk);
      #1;

      // Back-to-back accumulation on one address covers every history depth.
      op(OP_WRITE, 9'd7, 64'h0, 1'b0);
      repeat (4) op(OP_ADD, 9'd7, 64'h0001_0001_0001_0001, 1'b0);

      // Saturation, subtraction wrap and lane-isolated addition.
      op(OP_WRITE,   9'd9,  64'hFFF0_0001_7FFF_FFFF, 1'b0);
      op(OP_ADD_SAT, 9'd9,  64'h0020_0001_8000_0001, 1'b1);
      op(OP_WRITE,   9'd10, 64'h0, 1'b0);
      op(OP_SUB,     9'd10, 64'h0001_0000_0002_0001, 1'b0);
      op(OP_WRITE,   9'd11, 64'hFFFF_8000_0001_0000, 1'b0);
      op(OP_ADD,     9'd11, 64'h0001_8000_FFFF_0005, 1'b0);
      op(OP_WRITE,   9'd12, 64'h0001_0002_0003_0004, 1'b0);
      op(OP_ADD_SAT, 9'd12, 64'h0001_0001_0001_0001, 1'b0);

      // Interleaved hazards on two addresses.
      op(OP_WRITE, 9'd3, 64'h0005_0005_0005_0005, 1'b0);
      op(OP_WRITE, 9'd4, 64'h1000_2000_3000_4000, 1'b0);
      op(OP_ADD,   9'd3, 64'h0001_0001_0001_0001, 1'b0);
      op(OP_ADD,   9'd4, 64'h0002_0002_0002_0002, 1'b0);
      op(OP_ADD,   9'd3, 64'h0001_0001_0001_0001, 1'b0);
      op(OP_ADD,   9'd4, 64'h0002_0002_0002_0002, 1'b0);
      op(OP_SUB,   9'd3, 64'h0001_0001_0001_0001, 1'b0);
      idle(TB_RD_LAT + 3);

      rd(9'd6,  64'h0000_0000_0000_0100);
      rd(9'd7,  64'h0004_0004_0004_0004);
      rd(9'd9,  64'hFFFF_0002_FFFF_FFFF);
      rd(9'd10, 64'hFFFF_0000_FFFE_FFFF);
      rd(9'd11, 64'h0000_0000_0000_0005);
      rd(9'd12, 64'h0002_0003_0004_0005);
      rd(9'd3,  64'h0006_0006_0006_0006);
      rd(9'd4,  64'h1004_2004_3004_4004);
      drain();

      // Clear requested while ops are in flight.
      op(OP_ADD, 9'd3, 64'h0001_0001_0001_0001, 1'b0);
      op(OP_ADD, 9'd4, 64'h0001_0001_0001_0001, 1'b0);
      clr_start = 1'b1;
      op(OP_ADD, 9'd3, 64'h0001_0001_0001_0001, 1'b0);
      clr_start = 1'b0;
      n = 0;
      @(negedge clk);
      check("clr_wr_ready_low", 64'(wr_ready), 64'd0);
      check("clr_rd_ready_low", 64'(rd_ready), 64'd0);
      while (busy === 1'b1 && n < DEPTH + 100) begin
         n++;
         @(negedge clk);
      end
      check("clr_busy_cycles", 64'(n), 64'(TB_RD_LAT + 2 + DEPTH));
      check("clr_done_pulse", 64'(clr_done), 64'd1);
      check("clr_wr_ready_back", 64'(wr_ready), 64'd1);
      @(negedge clk);
      check("clr_done_single", 64'(clr_done), 64'd0);
      @(posedge clk);
      #1;
      rd(9'd3,   64'h0);
      rd(9'd4,   64'h0);
      rd(9'd9,   64'h0);
      rd(9'd511, 64'h0);
      drain();

      // Reset in the middle of a clear sweep.
      clr_start = 1'b1;
      idle(1);
      clr_start = 1'b0;
      repeat (20) @(negedge clk);
      check("mid_clear_busy", 64'(busy), 64'd1);
      #1;
      rstn = 1'b0;
      #1;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_mid_rd_ready", 64'(rd_ready), 64'd0);
      check("rst_mid_clr_done", 64'(clr_done), 64'd0);
      idle(2);
      rstn = 1'b1;
      idle(1);
      check("rst_rel_wr_ready", 64'(wr_ready), 64'd1);
      check("rst_rel_busy", 64'(busy), 64'd0);
      op(OP_WRITE, 9'd20, 64'hDEAD_BEEF_0123_4567, 1'b0);
      idle(TB_RD_LAT + 3);
      rd(9'd20, 64'hDEAD_BEEF_0123_4567);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/simd_acc_bank.md
Name: simd_acc_bank

Overview:
- Parametrised SIMD read-modify-write accumulator bank for the Frodo/Scloud datapath; next generation of the 16-bit-lane accumulator.
- Adds:
  - configurable lane width and RAM read latency;
  - four ops: WRITE, ADD, SUB, ADD_SAT;
  - valid/ready handshakes;
  - full-depth forwarding;
  - a hardware clear sweep FSM.
- Sits between the MAC array (write/accumulate side) and the result drain / readback logic (read side).

Parameters:
- ADDR_WIDTH, 9, entries = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, word width; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 16, SIMD lane width (8, 16 or 32).
- RD_LAT, 2, storage read latency in cycles (1..3).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- wr_valid  in  1  accumulate/write request valid
- wr_ready  out  1  request accepted when wr_valid && wr_ready
- wr_op  in  2  0=WRITE, 1=ADD, 2=SUB (old−data), 3=ADD_SAT (unsigned saturating)
- wr_addr  in  ADDR_WIDTH  target entry
- wr_data  in  DATA_WIDTH  operand, packed lanes
- rd_en  in  1  external read request
- rd_ready  out  1  external read accepted when rd_en && rd_ready
- rd_addr  in  ADDR_WIDTH  read entry
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  read result
- clr_start  in  1  one-cycle pulse: zero the whole bank
- busy  out  1  clear pending or in progress
- clr_done  out  1  one-cycle pulse when clear completes
- ovf  out  1  pulse: an ADD_SAT lane clipped, aligned with that op's RAM write

Behaviour:
- Reset (rstn=0, asynchronous), outputs: wr_ready=0, rd_ready=0, rd_valid=0, rd_data=0, busy=0, clr_done=0, ovf=0.
- Reset internal state: FSM=IDLE, pipeline and history valids cleared. RAM contents are not reset.
- Reset mid-clear or mid-op: everything abandons; partial writes remain in RAM.
- FSM states: IDLE, DRAIN, CLEAR.
  - IDLE: wr_ready=1.
  - clr_start in IDLE → DRAIN; wr_ready=0, busy=1 from the next cycle. clr_start outside IDLE is ignored.
  - DRAIN: wait until no pipeline stage is valid, then → CLEAR with sweep counter=0.
  - CLEAR: write 0 to address cnt each cycle. At cnt=2**ADDR_WIDTH−1, write, then → IDLE and pulse clr_done the same cycle busy falls.
- Request pipeline; accept at T0:
  - ops 1..3 issue a storage read of wr_addr at T0;
  - old data arrives at T0+RD_LAT, the compute stage;
  - result is registered and written to RAM at T0+RD_LAT+1;
  - WRITE skips the read and writes wr_data at T0+RD_LAT+1 (uniform latency keeps write order).
- Throughput: one request per cycle, back-to-back, any address mix.
- Forwarding:
  - history keeps the last RD_LAT+1 computed results (valid, addr, data), youngest first;
  - at the compute stage, the youngest matching valid entry replaces the RAM data;
  - this covers every in-flight hazard, given the storage returns old data on same-cycle read/write.
- Lane arithmetic: independent per lane, no carry between lanes.
  - ADD/SUB: modulo 2**LANE_WIDTH.
  - ADD_SAT: clamp to all-ones; ovf=1 if any lane clipped.
- Read port arbitration:
  - an accepted RMW request at T0 owns the read port, so rd_ready = !(wr_valid && wr_ready && wr_op!=0);
  - rd_ready is also 0 in DRAIN and CLEAR;
  - accepted read: rd_valid=1 at T+RD_LAT with rd_data from RAM, not forwarded;
  - reads of in-flight addresses return pre-update data (documented).
- rd_data holds its last value while rd_valid=0.

Decomposition:
- Package simd_acc_pkg:
  - acc_op_e enum (WRITE, ADD, SUB, ADD_SAT);
  - fsm state enum;
  - pipe_ctrl_t and hist_t struct typedefs, parameterised via localparam widths in the module.
- Sub-module simd_lane_alu, combinational: op, old, data → result, ovf; loops over DATA_WIDTH/LANE_WIDTH lanes.
- Storage: the existing pseudo dual-port RAM wrapper, with RD_LAT matched by output registers.

Test Plan:
- WRITE addr 5 = 0x0001_0002_0003_0004, then read addr 5 → rd_valid at T+RD_LAT, rd_data=0x0001_0002_0003_0004.
- Back-to-back ADD of 0x0001_0001_0001_0001 to addr 7 for 4 cycles (init 0) → read returns 0x0004_0004_0004_0004 (exercises every history depth).
- ADD_SAT lane 0xFFF0 + 0x0020, LANE_WIDTH=16 → lane = 0xFFFF, ovf pulses once; SUB 0x0000−0x0001 → 0xFFFF, ovf=0.
- Interleaved ADD stream to addrs 3,4,3,4 with RD_LAT=1 and RD_LAT=3 builds → both match the scoreboard.
- clr_start while requests are in flight → wr_ready drops; in-flight ops retire; busy lasts DRAIN+2**ADDR_WIDTH cycles; clr_done pulses; all reads then return 0.
- Assert rstn low mid-CLEAR → busy=0 and wr_ready=0 during reset; wr_ready=1 after release, FSM=IDLE.
